// File: rtl/ap_pkg.sv
// ap_pkg: command/state encodings and compare/write LUT contents for ap_vec_engine.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ap_pkg;

    localparam logic [2:0] CMD_OR  = 3'd0;
    localparam logic [2:0] CMD_XOR = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_NOT = 3'd3;
    localparam logic [2:0] CMD_ADD = 3'd4;
    localparam logic [2:0] CMD_SUB = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Passes per bit position.
    localparam logic [2:0] PASSES_LOGIC = 3'd4;
    localparam logic [2:0] PASSES_ARITH = 3'd5;

    // Logic truth tables, indexed by {A,B}.
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;
    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_NOT = 4'b0011;

    // Arithmetic pass entries {key_a, key_b, key_cr, wr_c, wr_cr} in pass order.
    // The order matters: a row whose Cr is rewritten must not match a later pass of the same bit.
    localparam logic [4:0] ADD_LUT [5] = '{5'b100_10, 5'b010_10, 5'b001_10, 5'b111_11, 5'b110_01};
    localparam logic [4:0] SUB_LUT [5] = '{5'b001_11, 5'b111_11, 5'b100_10, 5'b010_11, 5'b101_00};

    function automatic logic is_legal(input logic [2:0] c);
        return c <= CMD_SUB;
    endfunction

endpackage

// File: rtl/ap_lut_rom.sv
// ap_lut_rom: maps (cmd, pass) to compare keys and write values for one pass.
// Latency: combinational.
// Backpressure: none; ports: in cmd/pass, out key_a/key_b/key_cr/use_cr/wr_c/wr_cr/last_pass.
module ap_lut_rom
    import ap_pkg::*;
(
    input  logic [2:0] cmd,
    input  logic [2:0] pass,
    output logic       key_a,
    output logic       key_b,
    output logic       key_cr,
    output logic       use_cr,
    output logic       wr_c,
    output logic       wr_cr,
    output logic       last_pass
);

    logic [4:0] ent;
    logic [3:0] tt;

    always_comb begin
        ent       = 5'b0;
        tt        = 4'b0;
        key_a     = 1'b0;
        key_b     = 1'b0;
        key_cr    = 1'b0;
        use_cr    = 1'b0;
        wr_c      = 1'b0;
        wr_cr     = 1'b0;
        last_pass = 1'b1;
        case (cmd)
            CMD_OR, CMD_XOR, CMD_AND, CMD_NOT: begin
                case (cmd)
                    CMD_OR:  tt = TT_OR;
                    CMD_XOR: tt = TT_XOR;
                    CMD_AND: tt = TT_AND;
                    default: tt = TT_NOT;
                endcase
                // Logic passes walk (A,B) = 00,01,10,11.
                key_a     = pass[1];
                key_b     = pass[0];
                wr_c      = tt[pass[1:0]];
                last_pass = (pass == PASSES_LOGIC - 3'd1);
            end
            CMD_ADD, CMD_SUB: begin
                ent = (cmd == CMD_ADD) ? ADD_LUT[pass] : SUB_LUT[pass];
                {key_a, key_b, key_cr, wr_c, wr_cr} = ent;
                use_cr    = 1'b1;
                last_pass = (pass == PASSES_ARITH - 3'd1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ap_vec_engine.sv
// ap_vec_engine: bit-serial associative processor, ROWS words in columns A, B and C (C carries Cr in its MSB).
// Latency: host read 1 cycle; command done 1+2*P*WORD_SIZE edges after accept (illegal cmd: 1).
// Backpressure: cmd_ready only in IDLE; host access ignored while busy. Optional AP_CYCLE_CNT_EN adds op_cycles.
module ap_vec_engine
    import ap_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ROWS      = 16,
    parameter int ADDR_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [1:0]           sel_col,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [WORD_SIZE:0]   data_out,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd,
    input  logic [ADDR_W-1:0]    row_lo,
    input  logic [ADDR_W-1:0]    row_hi,
    output logic                 busy,
    output logic                 done
`ifdef AP_CYCLE_CNT_EN
    ,
    output logic [15:0]          op_cycles
`endif
);

    localparam int BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam int CIDX_W = $clog2(WORD_SIZE + 1);

    state_e              state_q;
    logic [2:0]          cmd_q;
    logic [ADDR_W-1:0]   lo_q, hi_q;
    logic [BIT_W-1:0]    bit_q;
    logic [2:0]          pass_q;
    logic                ready_q, busy_q, done_q;
    logic [ROWS-1:0]     tag_q;
    logic [WORD_SIZE-1:0] a_q [ROWS];
    logic [WORD_SIZE-1:0] b_q [ROWS];
    logic [WORD_SIZE:0]   c_q [ROWS];

    logic                rom_key_a, rom_key_b, rom_key_cr, rom_use_cr, rom_wr_c, rom_wr_cr, rom_last;
    logic [ROWS-1:0]     part;
    logic                addr_ok, bit_last, enter_done;
    logic [WORD_SIZE:0]  rd_word;
    logic [CIDX_W-1:0]   cbit;

    ap_lut_rom u_rom (
        .cmd       (cmd_q),
        .pass      (pass_q),
        .key_a     (rom_key_a),
        .key_b     (rom_key_b),
        .key_cr    (rom_key_cr),
        .use_cr    (rom_use_cr),
        .wr_c      (rom_wr_c),
        .wr_cr     (rom_wr_cr),
        .last_pass (rom_last)
    );

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign addr_ok    = (32'(addr_in) < ROWS);
    assign cbit       = CIDX_W'(bit_q);
    assign bit_last   = (bit_q == BIT_W'(WORD_SIZE - 1));
    assign enter_done = ((state_q == ST_CLEAR) && !is_legal(cmd_q)) ||
                        ((state_q == ST_WRITE) && rom_last && bit_last);

    // An empty range (lo > hi) simply leaves every participation bit clear.
    always_comb begin
        part = '0;
        for (int r = 0; r < ROWS; r++) begin
            part[r] = (32'(lo_q) <= 32'(r)) && (32'(r) <= 32'(hi_q));
        end
    end

    always_comb begin
        rd_word = '0;
        if (addr_ok) begin
            case (sel_col)
                2'd0:    rd_word = {1'b0, a_q[addr_in]};
                2'd1:    rd_word = {1'b0, b_q[addr_in]};
                2'd2:    rd_word = c_q[addr_in];
                default: rd_word = '0;
            endcase
        end
    end

    // Array storage, tags and host port. Host access only happens in IDLE, engine
    // updates only outside IDLE, so the two never collide on the same edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
                c_q[r] <= '0;
            end
            tag_q    <= '0;
            data_out <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (write_en && addr_ok) begin
                    case (sel_col)
                        2'd0:    a_q[addr_in] <= data_in;
                        2'd1:    b_q[addr_in] <= data_in;
                        2'd2:    c_q[addr_in] <= {1'b0, data_in};
                        default: ;
                    endcase
                end
                if (read_en) begin
                    data_out <= rd_word;
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                case (state_q)
                    ST_CLEAR: begin
                        if (part[r] && is_legal(cmd_q)) c_q[r] <= '0;
                    end
                    ST_COMPARE: begin
                        tag_q[r] <= part[r] &&
                                    (a_q[r][bit_q] == rom_key_a) &&
                                    (b_q[r][bit_q] == rom_key_b) &&
                                    (!rom_use_cr || (c_q[r][WORD_SIZE] == rom_key_cr));
                    end
                    ST_WRITE: begin
                        if (tag_q[r]) begin
                            c_q[r][cbit] <= rom_wr_c;
                            if (rom_use_cr) c_q[r][WORD_SIZE] <= rom_wr_cr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            bit_q   <= '0;
            pass_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q   <= cmd;
                        lo_q    <= row_lo;
                        hi_q    <= row_hi;
                        bit_q   <= '0;
                        pass_q  <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // Illegal commands still spend this cycle so done lands after edge 1.
                    if (enter_done) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: state_q <= ST_WRITE;
                ST_WRITE: begin
                    if (rom_last) begin
                        pass_q <= '0;
                        if (bit_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= ST_COMPARE;
                        end
                    end else begin
                        pass_q  <= pass_q + 3'd1;
                        state_q <= ST_COMPARE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AP_CYCLE_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] op_cycles_q;

    assign op_cycles = op_cycles_q;

    // cnt_q is 0 right after the accept edge, so cnt_q+1 counts edges up to and including DONE entry.
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q       <= '0;
            op_cycles_q <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (enter_done) begin
                op_cycles_q <= (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ap_vec_engine.sv
// tb_ap_vec_engine: directed and randomized checks of ap_vec_engine against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ap_vec_engine;

    logic       clock;
    logic       rst;
    logic [3:0] addr_in;
    logic [1:0] sel_col;
    logic [7:0] data_in;
    logic       write_en;
    logic       read_en;
    logic [8:0] data_out;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [3:0] row_lo;
    logic [3:0] row_hi;
    logic       busy;
    logic       done;
`ifdef AP_CYCLE_CNT_EN
    logic [15:0] op_cycles;
`endif

    ap_vec_engine #(.WORD_SIZE(8), .ROWS(16)) dut (
        .clock     (clock),
        .rst       (rst),
        .addr_in   (addr_in),
        .sel_col   (sel_col),
        .data_in   (data_in),
        .write_en  (write_en),
        .read_en   (read_en),
        .data_out  (data_out),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .row_lo    (row_lo),
        .row_hi    (row_hi),
        .busy      (busy),
        .done      (done)
`ifdef AP_CYCLE_CNT_EN
        ,
        .op_cycles (op_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference contents of the three columns.
    logic [7:0] ma [16];
    logic [7:0] mb [16];
    logic [8:0] mc [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [8:0] model_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            3'd0:    return {1'b0, a | b};
            3'd1:    return {1'b0, a ^ b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, ~a};
            3'd4:    return 9'(a) + 9'(b);
            3'd5:    return 9'(a) - 9'(b);
            default: return 9'd0;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] c);
        if (c >= 3'd6) return 1;
        if (c >= 3'd4) return 1 + 2 * 5 * 8;
        return 1 + 2 * 4 * 8;
    endfunction

    task automatic host_wr(input logic [1:0] col, input logic [3:0] addr, input logic [7:0] d);
        sel_col  = col;
        addr_in  = addr;
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        case (col)
            2'd0:    ma[addr] = d;
            2'd1:    mb[addr] = d;
            2'd2:    mc[addr] = {1'b0, d};
            default: ;
        endcase
    endtask

    task automatic host_rd(input logic [1:0] col, input logic [3:0] addr, output logic [8:0] d);
        sel_col = col;
        addr_in = addr;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        d = data_out;
    endtask

    task automatic verify_all(input string tag);
        logic [8:0] d;
        for (int r = 0; r < 16; r++) begin
            host_rd(2'd0, 4'(r), d);
            check_eq($sformatf("%s_a%0d", tag, r), 32'(d), 32'(ma[r]));
            host_rd(2'd1, 4'(r), d);
            check_eq($sformatf("%s_b%0d", tag, r), 32'(d), 32'(mb[r]));
            host_rd(2'd2, 4'(r), d);
            check_eq($sformatf("%s_c%0d", tag, r), 32'(d), 32'(mc[r]));
        end
    endtask

    // Issues one command; optional: hold cmd_valid throughout, host write of A[lo]=0x55 while busy,
    // host write of A[lo]=co_dat on the accept edge itself.
    task automatic run_cmd(input logic [2:0] c, input logic [3:0] lo, input logic [3:0] hi,
                           input bit hold_valid, input bit mid_wr, input bit co_wr, input logic [7:0] co_dat);
        int k;
        bit ready_hi;
        bit got_done;
        cmd       = c;
        row_lo    = lo;
        row_hi    = hi;
        cmd_valid = 1'b1;
        if (co_wr) begin
            sel_col  = 2'd0;
            addr_in  = lo;
            data_in  = co_dat;
            write_en = 1'b1;
            ma[lo]   = co_dat;
        end
        check_eq("rdy_idle", 32'(cmd_ready), 32'd1);
        tick();
        write_en = 1'b0;
        if (!hold_valid) cmd_valid = 1'b0;
        check_eq("busy_acc", 32'(busy), 32'd1);
        check_eq("rdy_acc", 32'(cmd_ready), 32'd0);
        k = 0;
        got_done = 0;
        ready_hi = 0;
        while (k < 300 && !got_done) begin
            if (mid_wr && k == 10) begin
                sel_col  = 2'd0;
                addr_in  = lo;
                data_in  = 8'h55;
                write_en = 1'b1;
            end
            tick();
            k++;
            write_en = 1'b0;
            if (cmd_ready) ready_hi = 1;
            if (done) got_done = 1;
        end
        cmd_valid = 1'b0;
        check_eq($sformatf("done_seen_c%0d", c), 32'(got_done), 32'd1);
        check_eq($sformatf("latency_c%0d", c), k, lat(c));
`ifdef AP_CYCLE_CNT_EN
        check_eq($sformatf("op_cycles_c%0d", c), 32'(op_cycles), lat(c));
`endif
        if (hold_valid) check_eq("rdy_while_busy", 32'(ready_hi), 32'd0);
        tick();
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("rdy_back", 32'(cmd_ready), 32'd1);
        check_eq("busy_clr", 32'(busy), 32'd0);
        if (c <= 3'd5) begin
            for (int r = 0; r < 16; r++) begin
                if (lo <= 4'(r) && 4'(r) <= hi) mc[r] = model_op(c, ma[r], mb[r]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        logic [8:0] exp_logic [4];
        bit         got_done;
        rst       = 1'b1;
        addr_in   = '0;
        sel_col   = '0;
        data_in   = '0;
        write_en  = 1'b0;
        read_en   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = '0;
        row_lo    = '0;
        row_hi    = '0;
        for (int r = 0; r < 16; r++) begin
            ma[r] = '0;
            mb[r] = '0;
            mc[r] = '0;
        end
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
`ifdef AP_CYCLE_CNT_EN
        check_eq("rst_op_cycles", 32'(op_cycles), 32'd0);
`endif

        // ADD on rows 0..3.
        host_wr(2'd0, 4'd0, 8'd3);   host_wr(2'd1, 4'd0, 8'd5);
        host_wr(2'd0, 4'd1, 8'd255); host_wr(2'd1, 4'd1, 8'd1);
        host_wr(2'd0, 4'd2, 8'd128); host_wr(2'd1, 4'd2, 8'd128);
        host_wr(2'd0, 4'd3, 8'd0);   host_wr(2'd1, 4'd3, 8'd0);
        run_cmd(3'd4, 4'd0, 4'd3, 0, 0, 0, 8'd0);
        host_rd(2'd2, 4'd0, d); check_eq("add_r0", 32'(d), 32'h008);
        host_rd(2'd2, 4'd1, d); check_eq("add_r1", 32'(d), 32'h100);
        host_rd(2'd2, 4'd2, d); check_eq("add_r2", 32'(d), 32'h100);
        host_rd(2'd2, 4'd3, d); check_eq("add_r3", 32'(d), 32'h000);

        // SUB with and without borrow.
        host_wr(2'd0, 4'd0, 8'd5); host_wr(2'd1, 4'd0, 8'd3);
        host_wr(2'd0, 4'd1, 8'd3); host_wr(2'd1, 4'd1, 8'd5);
        run_cmd(3'd5, 4'd0, 4'd1, 0, 0, 0, 8'd0);
        host_rd(2'd2, 4'd0, d); check_eq("sub_r0", 32'(d), 32'h002);
        host_rd(2'd2, 4'd1, d); check_eq("sub_r1", 32'(d), 32'h1FE);

        // Logic ops on A=F0, B=CC.
        exp_logic = '{9'h0FC, 9'h03C, 9'h0C0, 9'h00F};
        host_wr(2'd0, 4'd0, 8'hF0); host_wr(2'd1, 4'd0, 8'hCC);
        for (int op = 0; op < 4; op++) begin
            run_cmd(3'(op), 4'd0, 4'd0, 0, 0, 0, 8'd0);
            host_rd(2'd2, 4'd0, d);
            check_eq($sformatf("logic_op%0d", op), 32'(d), 32'(exp_logic[op]));
        end

        // Row range: rows outside 2..3 keep their preloaded C.
        host_wr(2'd2, 4'd0, 8'hAA); host_wr(2'd2, 4'd1, 8'hAA);
        host_wr(2'd0, 4'd2, 8'd200); host_wr(2'd1, 4'd2, 8'd100);
        host_wr(2'd0, 4'd3, 8'd17);  host_wr(2'd1, 4'd3, 8'd25);
        run_cmd(3'd4, 4'd2, 4'd3, 0, 0, 0, 8'd0);
        host_rd(2'd2, 4'd0, d); check_eq("range_r0", 32'(d), 32'h0AA);
        host_rd(2'd2, 4'd1, d); check_eq("range_r1", 32'(d), 32'h0AA);
        host_rd(2'd2, 4'd2, d); check_eq("range_r2", 32'(d), 32'h12C);
        host_rd(2'd2, 4'd3, d); check_eq("range_r3", 32'(d), 32'h02A);
        verify_all("range");

        // Busy: cmd_valid held high and a host write while busy.
        run_cmd(3'd4, 4'd0, 4'd15, 1, 1, 0, 8'd0);
        verify_all("busy");

        // Host write on the accept edge feeds the command.
        host_wr(2'd1, 4'd2, 8'h0F);
        run_cmd(3'd0, 4'd2, 4'd2, 0, 0, 1, 8'h30);
        host_rd(2'd2, 4'd2, d); check_eq("co_write", 32'(d), 32'h03F);

        // Illegal command and an empty range leave the arrays alone.
        run_cmd(3'd7, 4'd0, 4'd15, 0, 0, 0, 8'd0);
        run_cmd(3'd4, 4'd9, 4'd3, 0, 0, 0, 8'd0);
        verify_all("noop");
        host_rd(2'd3, 4'd1, d); check_eq("rd_sel3", 32'(d), 32'd0);

        // Randomized host traffic and commands.
        for (int it = 0; it < 20; it++) begin
            logic [2:0] c;
            logic [3:0] lo, hi;
            for (int w = 0; w < 5; w++) begin
                host_wr(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom));
            end
            c  = 3'($urandom_range(0, 7));
            lo = 4'($urandom_range(0, 15));
            hi = 4'($urandom_range(0, 15));
            run_cmd(c, lo, hi, 0, 0, 0, 8'd0);
            verify_all($sformatf("rnd%0d", it));
        end

        // Reset at edge 40 of an ADD abandons it.
        host_wr(2'd0, 4'd5, 8'h77);
        cmd = 3'd4; row_lo = 4'd0; row_hi = 4'd15; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k < 40; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            ma[r] = '0;
            mb[r] = '0;
            mc[r] = '0;
        end
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_dout", 32'(data_out), 32'd0);
        got_done = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) got_done = 1;
        end
        check_eq("mid_rst_no_done", 32'(got_done), 32'd0);
        verify_all("rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_vec_engine.md
# ap_vec_engine

Parametrised bit-serial associative processor over ROWS words held in three columns: A and B are WORD_SIZE bits wide, C is WORD_SIZE+1 bits wide, with the carry/borrow in the MSB. It is the successor to the fixed 8-bit CAM-based AP slice and sits behind the same host word-access port. It adds:

- a valid/ready command handshake with busy and done;
- a per-command row range;
- a clear phase, so results never depend on stale C contents.

All rows execute the command in parallel using LUT-driven compare/write passes.

## Interface
- WORD_SIZE, 8: bits per A/B word; C is WORD_SIZE+1.
- ROWS, 16: words per column.
- ADDR_W, derived clogb2(ROWS): row address width.

- clock  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- addr_in  in  ADDR_W  host row address
- sel_col  in  2  column select: 0=A, 1=B, 2=C, 3=none
- data_in  in  WORD_SIZE  host write data
- write_en  in  1  host write strobe
- read_en  in  1  host read strobe
- data_out  out  WORD_SIZE+1  registered read data
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd  in  3  0=OR, 1=XOR, 2=AND, 3=NOT(A), 4=ADD(A+B), 5=SUB(A−B)
- row_lo, row_hi  in  ADDR_W each  inclusive participating row range, latched on accept
- busy  out  1  high from the accept edge until return to IDLE
- done  out  1  single-cycle pulse while in DONE
- op_cycles  out  16  present only with AP_CYCLE_CNT_EN

## Operation

**States:** IDLE → CLEAR → COMPARE ⇄ WRITE → DONE → IDLE.

**Command accept**
- A command is accepted on an edge where cmd_valid && cmd_ready. cmd, row_lo and row_hi are latched at that edge.
- cmd 6 or 7: go straight to DONE; no array change.

**CLEAR:** C := 0, including the carry bit, for every participating row. A row participates when row_lo ≤ row ≤ row_hi. If row_lo > row_hi, no row participates, but the full timing still runs.

**Pass sequencing**
- Bits i run from 0 to WORD_SIZE−1; within each bit, pass p runs from 0 to P−1.
- P is 4 for the logic commands and 5 for ADD/SUB.

**COMPARE:** register tag[r] for each participating row r. tag[r] is high when A[i], B[i] and (for ADD/SUB only) Cr all equal the pass keys.

**WRITE:** each tagged row writes C[i]. For ADD/SUB it also writes Cr. The pass counter then advances; after the last pass of bit WORD_SIZE−1 the FSM goes to DONE.

**Logic LUT:** passes are (A,B) = 00, 01, 10, 11 in that order; each writes the op result. NOT ignores B.

**ADD passes, key (A,B,Cr) → write (C,Cr), in order:**
- (1,0,0) → (1,0)
- (0,1,0) → (1,0)
- (0,0,1) → (1,0)
- (1,1,1) → (1,1)
- (1,1,0) → (0,1)

**SUB passes, in order:**
- (0,0,1) → (1,1)
- (1,1,1) → (1,1)
- (1,0,0) → (1,0)
- (0,1,0) → (1,1)
- (1,0,1) → (0,0)

**Host access (IDLE only)**
- write_en writes data_in to the selected column at addr_in; a C write zero-extends, so Cr = 0.
- read_en loads data_out with the selected word, zero-extended for A/B.
- sel_col=3 or addr_in ≥ ROWS: write ignored, read returns 0.
- While busy, write_en and read_en are ignored and data_out holds its value.
- A write and a command accept on the same edge: the write lands first, and the command uses the written value.

## Timing

**Reset**
- Reset state: IDLE; all A/B/C contents 0; data_out=0, busy=0, done=0, cmd_ready=1, op_cycles=0.
- rst mid-operation abandons the command with no done pulse.

**Latency and handshake**
- Host read latency is 1 cycle.
- The accept edge is edge 0. done is high during the cycle after edge 1+2·P·WORD_SIZE; with WORD_SIZE=8, that is edge 81 for ADD/SUB and edge 65 for logic ops. For an illegal cmd, done follows edge 1.
- cmd_ready returns high the cycle after done. Back-to-back commands are therefore separated by at least one IDLE cycle.

## Configuration
- AP_CYCLE_CNT_EN defined:
  - op_cycles exists.
  - A counter runs from the accept edge; its value is loaded into op_cycles on entry to DONE, saturating at 16'hFFFF.
  - op_cycles holds its value until the next DONE or rst.
- AP_CYCLE_CNT_EN undefined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Package ap_pkg holds:
  - the cmd encodings and the FSM state encoding;
  - the logic/ADD/SUB LUT constants and the per-cmd pass counts.
- Sub-module ap_lut_rom is combinational:
  - inputs: cmd, pass;
  - outputs: key_a, key_b, key_cr, use_cr, wr_c, wr_cr, last_pass.
- Array storage, tag registers and the FSM live in ap_vec_engine.

## Test plan
- **ADD:** rows 0–3 with A={3,255,128,0} and B={5,1,128,0}, range 0..3 → C={0x008,0x100,0x100,0x000}; done at edge 81.
- **SUB:** A={5,3}, B={3,5} → C={0x002,0x1FE}.
- **Logic:** A=0xF0, B=0xCC → OR 0x0FC, XOR 0x03C, AND 0x0C0, NOT 0x00F; each done at edge 65.
- **Row range:** preload C=0x0AA in rows 0–1, then ADD with range 2..3 → rows 0–1 read back 0x0AA, rows 2–3 hold correct sums.
- **Busy and reset:**
  - write_en A=0x55 mid-op → ignored, and readback after done is unchanged.
  - cmd_valid held high → cmd_ready stays 0 until IDLE.
  - rst at edge 40 → no done, all reads return 0, cmd_ready=1.
- **AP_CYCLE_CNT_EN defined:** ADD → op_cycles=81; illegal cmd 7 → op_cycles=1 and arrays unchanged.
